// File: rtl/four_bit_seq_multiplier_pkg.sv
// Shared definitions for the 4x4 sequential shift-add multiplier:
// operand/product widths, FSM state encoding and the full-adder helper
// used by the ripple-carry adder.
package four_bit_seq_multiplier_pkg;

  localparam int WIDTH  = 4;
  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = 3;

  // 2'd3 is unused; the FSM recovers from it to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One-bit full adder, returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    full_add = {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/four_bit_seq_multiplier_if.sv
// Start/busy/done handshake plus operand and product bus of the
// sequential multiplier. The requester uses the master modport, the
// multiplier the slave modport.
interface four_bit_seq_multiplier_if;
  import four_bit_seq_multiplier_pkg::*;

  logic              start;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] P;

  modport master (output start, output A, output B,
                  input  busy,  input  done, input P);

  modport slave  (input  start, input  A, input  B,
                  output busy,  output done, output P);

endinterface

// File: rtl/four_bit_rca.sv
// Combinational 4-bit ripple-carry adder built from a chain of full adders.
module four_bit_rca
  import four_bit_seq_multiplier_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic c1_s;
  logic c2_s;
  logic c3_s;

  assign {c1_s,   sum_o[0]} = full_add(a_i[0], b_i[0], cin_i);
  assign {c2_s,   sum_o[1]} = full_add(a_i[1], b_i[1], c1_s);
  assign {c3_s,   sum_o[2]} = full_add(a_i[2], b_i[2], c2_s);
  assign {cout_o, sum_o[3]} = full_add(a_i[3], b_i[3], c3_s);

endmodule

// File: rtl/four_bit_seq_multiplier.sv
// Unsigned 4x4 shift-add multiplier, 8-bit product over several cycles.
// FSM IDLE -> RUN (4 add/shift passes) -> DONE -> IDLE; busy, done and P
// are registered. The only adder is the four_bit_rca instance.
// Optional build macro ZERO_SKIP_EN: a zero operand collapses RUN to a
// single pass over cleared registers, so done follows two edges after the
// accepted start instead of five. Products are identical in both builds.
module four_bit_seq_multiplier
  import four_bit_seq_multiplier_pkg::*;
(
  input logic                      clk,
  input logic                      rst_n,
  four_bit_seq_multiplier_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  m_q,     m_d;
  logic [WIDTH-1:0]  acc_q,   acc_d;
  logic [WIDTH-1:0]  q_q,     q_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [PROD_W-1:0] p_q,     p_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic [WIDTH-1:0]  addend_s;
  logic [WIDTH-1:0]  sum_s;
  logic              carry_s;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign addend_s = q_q[0] ? m_q : 4'h0;

  four_bit_rca u_rca (
    .a_i    (acc_q),
    .b_i    (addend_s),
    .cin_i  (1'b0),
    .sum_o  (sum_s),
    .cout_o (carry_s)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.P    = p_q;

  // Next-state, datapath and output decode; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d     = bus.A;
          acc_d   = 4'h0;
          cnt_d   = 3'd0;
          state_d = S_RUN;
`ifdef ZERO_SKIP_EN
          if ((bus.A == 4'h0) || (bus.B == 4'h0)) begin
            // Zero product: one pass over cleared ACC/Q yields P = 0.
            q_d   = 4'h0;
            cnt_d = LAST_CNT;
          end else begin
            q_d   = bus.B;
          end
`else
          q_d     = bus.B;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // 9-bit {C,S,Q} shifted right by one: carry lands in ACC[3].
        acc_d = {carry_s, sum_s[3:1]};
        q_d   = {sum_s[0], q_q[3:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        p_d     = {acc_q, q_q};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d == S_RUN) || (state_d == S_DONE)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= 4'h0;
      acc_q   <= 4'h0;
      q_q     <= 4'h0;
      cnt_q   <= 3'd0;
      p_q     <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_four_bit_seq_multiplier.sv
// Self-checking bench for four_bit_seq_multiplier: expected products and
// latencies are queued at issue time and popped when done is seen.
module tb_four_bit_seq_multiplier;

  typedef struct {
    logic [7:0] prod;
    int         t;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  four_bit_seq_multiplier_if bus_if ();

  four_bit_seq_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lat_for(input logic [3:0] a, input logic [3:0] b);
`ifdef ZERO_SKIP_EN
    return ((a == 4'd0) || (b == 4'd0)) ? 2 : 5;
`else
    return 5;
`endif
  endfunction

  // Scoreboard: every done pulse must match the oldest pending request.
  always @(negedge clk) begin
    if (bus_if.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_val("done_unexpected", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("product", bus_if.P, e.prod);
        check_val("latency", cyc - e.t, e.lat);
      end
    end
  end

  // Called at negedge+1 with the DUT idle; start is sampled at the next edge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    bus_if.A     = a;
    bus_if.B     = b;
    bus_if.start = 1'b1;
    e.prod = {4'd0, a} * {4'd0, b};
    e.t    = cyc + 1;
    e.lat  = lat_for(a, b);
    exp_q.push_back(e);
    @(negedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int k;
    k = 0;
    while ((done_cnt == prev) && (k < 20)) begin
      @(negedge clk); #1;
      k++;
    end
    check_val("done_wait", done_cnt, prev + 1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    int prev;
    int d0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.A     = 4'd0;
    bus_if.B     = 4'd0;
    step(2);
    check_val("rst_busy", bus_if.busy, 0);
    check_val("rst_done", bus_if.done, 0);
    check_val("rst_P",    bus_if.P,    0);
    rst_n = 1'b1;
    step(1);

    // 3*5: busy for exactly five cycles, then done with P=15.
    prev = done_cnt;
    issue(4'd3, 4'd5);
    check_val("busy_k0", bus_if.busy, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      check_val($sformatf("busy_k%0d", k), bus_if.busy, (k < 5) ? 1 : 0);
    end
    wait_done(prev);
    step(1);

    // Carry path and a few other patterns, plus a zero operand.
    prev = done_cnt; issue(4'd15, 4'd15); wait_done(prev);
    prev = done_cnt; issue(4'd15, 4'd1);  wait_done(prev);
    prev = done_cnt; issue(4'd0,  4'd9);  wait_done(prev);
    prev = done_cnt; issue(4'd12, 4'd11); wait_done(prev);
    step(2);

    // Restarts during RUN and in the DONE cycle must be ignored.
    prev = done_cnt;
    issue(4'd7, 4'd6);
    @(negedge clk); #1;
    bus_if.start = 1'b1; bus_if.A = 4'd2; bus_if.B = 4'd2;
    @(negedge clk); #1;
    @(negedge clk); #1;
    bus_if.start = 1'b0;
    @(negedge clk); #1;
    bus_if.start = 1'b1;
    @(negedge clk); #1;
    bus_if.start = 1'b0;
    step(8);
    check_val("one_done", done_cnt - prev, 1);

    // Reset two edges into a run aborts it silently.
    prev = done_cnt;
    issue(4'd9, 4'd9);
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    exp_q.delete();
    check_val("abort_busy", bus_if.busy, 0);
    check_val("abort_done", bus_if.done, 0);
    check_val("abort_P",    bus_if.P,    0);
    rst_n = 1'b1;
    step(8);
    check_val("abort_no_done", done_cnt, prev);
    prev = done_cnt; issue(4'd9, 4'd9); wait_done(prev);

    // Exhaustive, back-to-back: each start lands in the cycle done is high.
    d0 = done_cnt;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        prev = done_cnt;
        issue(4'(a), 4'(b));
        wait_done(prev);
      end
    end
    step(4);
    check_val("done_count", done_cnt - d0, 256);
    check_val("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
